// File: rtl/dbi_decode_32b_if.sv
// Link and output-side handshake bundle for the DBI decoder.
// Link: {dbi_flag, data} under valid/ready; output: decoded data under valid/ready.
interface dbi_decode_32b_if #(
   parameter int BW = 32
);
   logic [BW:0]   bus_in;
   logic          bus_valid;
   logic          bus_ready;
   logic [BW-1:0] data_out;
   logic          out_valid;
   logic          out_ready;

   modport master (
      output bus_in,
      output bus_valid,
      input  bus_ready,
      input  data_out,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  bus_in,
      input  bus_valid,
      output bus_ready,
      output data_out,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/dbi_decode_32b.sv
// DBI receive stage: re-inverts flagged link words into a small output FIFO
// and keeps saturating word/inversion/toggle statistics of the link.
module dbi_decode_32b #(
   parameter int BW    = 32,
   parameter int DEPTH = 2,
   parameter int CW    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dbi_en,
   input  logic              clear_stats,
   dbi_decode_32b_if.slave   bus,
   output logic [CW-1:0]     word_cnt,
   output logic [CW-1:0]     inv_cnt,
   output logic [CW-1:0]     toggle_cnt
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(BW + 2);
   localparam int SW = CW + PW;
   localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] L_MAX  = '1;

   logic [BW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [BW:0]   r_prev_link;
   logic [CW-1:0] r_word_cnt;
   logic [CW-1:0] r_inv_cnt;
   logic [CW-1:0] r_toggle_cnt;

   logic          w_inv;
   logic [BW-1:0] w_dec;
   logic          w_push;
   logic          w_pop;
   logic [PW-1:0] w_toggles;
   logic [CW-1:0] w_word_base;
   logic [CW-1:0] w_inv_base;
   logic [CW-1:0] w_tog_base;

   function automatic logic [PW-1:0] f_popcount(input logic [BW:0] v);
      logic [PW-1:0] n;
      n = '0;
      for (int i = 0; i <= BW; i++) begin
         n = n + PW'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [CW-1:0] f_sat_add(
      input logic [CW-1:0] base,
      input logic [PW-1:0] inc
   );
      logic [SW-1:0] s;
      s = SW'(base) + SW'(inc);
      return (s > SW'(L_MAX)) ? L_MAX : s[CW-1:0];
   endfunction

   assign w_inv     = dbi_en && bus.bus_in[BW];
   assign w_dec     = w_inv ? ~bus.bus_in[BW-1:0] : bus.bus_in[BW-1:0];
   assign w_push    = bus.bus_valid && (r_count < L_FULL);
   assign w_pop     = (r_count != '0) && bus.out_ready;
   assign w_toggles = f_popcount(bus.bus_in ^ r_prev_link);

   // Clear takes effect before a same-cycle accept adds its contribution
   assign w_word_base = clear_stats ? '0 : r_word_cnt;
   assign w_inv_base  = clear_stats ? '0 : r_inv_cnt;
   assign w_tog_base  = clear_stats ? '0 : r_toggle_cnt;

   assign bus.bus_ready = (r_count < L_FULL);
   assign bus.out_valid = (r_count != '0);
   assign bus.data_out  = r_mem[r_rd_ptr];

   assign word_cnt   = r_word_cnt;
   assign inv_cnt    = r_inv_cnt;
   assign toggle_cnt = r_toggle_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_link  <= '0;
         r_word_cnt   <= '0;
         r_inv_cnt    <= '0;
         r_toggle_cnt <= '0;
      end else if (w_push) begin
         r_prev_link  <= bus.bus_in;
         r_word_cnt   <= f_sat_add(w_word_base, PW'(1));
         r_inv_cnt    <= f_sat_add(w_inv_base, PW'(w_inv));
         r_toggle_cnt <= f_sat_add(w_tog_base, w_toggles);
      end else if (clear_stats) begin
         r_word_cnt   <= '0;
         r_inv_cnt    <= '0;
         r_toggle_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_dbi_decode_32b.sv
// Scenario bench for dbi_decode_32b: scoreboard on the output stream plus
// inline statistic checks; a CW=4 instance covers counter saturation.
module tb_dbi_decode_32b;
   logic        clk = 1'b0;
   logic        reset;
   logic        dbi_en;
   logic        clear_stats;
   logic [31:0] word_cnt, inv_cnt, toggle_cnt;
   logic [3:0]  s_word, s_inv, s_tog;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb [$];
   logic [31:0] m_exp;

   dbi_decode_32b_if #(.BW(32)) bm ();
   dbi_decode_32b_if #(.BW(32)) bs ();

   dbi_decode_32b #(.BW(32), .DEPTH(2), .CW(32)) u_dut (
      .clk(clk), .reset(reset), .dbi_en(dbi_en),
      .clear_stats(clear_stats), .bus(bm),
      .word_cnt(word_cnt), .inv_cnt(inv_cnt), .toggle_cnt(toggle_cnt)
   );

   dbi_decode_32b #(.BW(32), .DEPTH(2), .CW(4)) u_sat (
      .clk(clk), .reset(reset), .dbi_en(dbi_en),
      .clear_stats(clear_stats), .bus(bs),
      .word_cnt(s_word), .inv_cnt(s_inv), .toggle_cnt(s_tog)
   );

   always #5 clk = ~clk;

   // Expected words enter the queue as they are offered and accepted
   always @(negedge clk) begin
      if (!reset) begin
         if (bm.out_valid && bm.out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_empty: got %h, no word expected", bm.data_out);
            end else begin
               m_exp = sb.pop_front();
               if (bm.data_out !== m_exp) begin
                  n_fail++;
                  $display("FAIL sb_data: got %h, want %h", bm.data_out, m_exp);
               end
            end
         end
         if (bm.bus_valid && bm.bus_ready)
            sb.push_back((dbi_en && bm.bus_in[32]) ? ~bm.bus_in[31:0] : bm.bus_in[31:0]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bm.bus_valid = 1'b0;
      bs.bus_valid = 1'b0;
      reset = 1'b1;
      cyc();
      cyc();
      sb.delete();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (bm.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_valid: got %b, want 0", bm.out_valid);
      end
      n_tests++;
      if (bm.bus_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_ready: got %b, want 1", bm.bus_ready);
      end
      n_tests++;
      if (bm.data_out !== 32'h0) begin
         n_fail++; $display("FAIL rst_data: got %h, want 0", bm.data_out);
      end
      n_tests++;
      if ({word_cnt, inv_cnt, toggle_cnt} !== 96'h0) begin
         n_fail++;
         $display("FAIL rst_cnt: got %0d/%0d/%0d, want 0/0/0", word_cnt, inv_cnt, toggle_cnt);
      end
   endtask

   task automatic test_decode();
      bm.out_ready = 1'b1;
      dbi_en = 1'b1;
      bm.bus_in = {1'b1, 32'h0};
      bm.bus_valid = 1'b1;
      cyc();
      bm.bus_valid = 1'b0;
      n_tests++;
      if (bm.out_valid !== 1'b1 || bm.data_out !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL dec_inv: got %b/%h, want 1/ffffffff", bm.out_valid, bm.data_out);
      end
      n_tests++;
      if (word_cnt !== 1 || inv_cnt !== 1 || toggle_cnt !== 1) begin
         n_fail++;
         $display("FAIL dec_cnt: got %0d/%0d/%0d, want 1/1/1", word_cnt, inv_cnt, toggle_cnt);
      end
      cyc();
      dbi_en = 1'b0;
      bm.bus_in = {1'b1, 32'h1234_5678};
      bm.bus_valid = 1'b1;
      cyc();
      n_tests++;
      if (bm.data_out !== 32'h1234_5678 || inv_cnt !== 1) begin
         n_fail++;
         $display("FAIL dec_off: got %h inv %0d, want 12345678 inv 1", bm.data_out, inv_cnt);
      end
      dbi_en = 1'b1;
      cyc();
      bm.bus_valid = 1'b0;
      n_tests++;
      if (bm.data_out !== 32'hEDCB_A987 || inv_cnt !== 2 || word_cnt !== 3) begin
         n_fail++;
         $display("FAIL dec_on: got %h inv %0d words %0d, want edcba987 2 3",
                  bm.data_out, inv_cnt, word_cnt);
      end
      cyc();
   endtask

   task automatic test_backpressure();
      dbi_en = 1'b0;
      bm.out_ready = 1'b0;
      bm.bus_valid = 1'b1;
      bm.bus_in = {1'b0, 32'hAAAA_0001};
      cyc();
      bm.bus_in = {1'b0, 32'hBBBB_0002};
      cyc();
      n_tests++;
      if (bm.bus_ready !== 1'b0 || bm.data_out !== 32'hAAAA_0001) begin
         n_fail++;
         $display("FAIL bp_full: got rdy %b data %h, want 0 aaaa0001", bm.bus_ready, bm.data_out);
      end
      bm.bus_in = {1'b0, 32'hCCCC_0003};
      cyc();
      n_tests++;
      if (bm.bus_ready !== 1'b0 || bm.data_out !== 32'hAAAA_0001 || bm.out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: got rdy %b data %h vld %b, want 0 aaaa0001 1",
                  bm.bus_ready, bm.data_out, bm.out_valid);
      end
      bm.out_ready = 1'b1;
      cyc();
      n_tests++;
      if (bm.bus_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_reopen: got %b, want 1", bm.bus_ready);
      end
      cyc();
      bm.bus_valid = 1'b0;
      cyc();
      cyc();
      n_tests++;
      if (bm.out_valid !== 1'b0 || word_cnt !== 6) begin
         n_fail++;
         $display("FAIL bp_drain: got vld %b words %0d, want 0 6", bm.out_valid, word_cnt);
      end
   endtask

   task automatic test_back_to_back();
      dbi_en = 1'b1;
      bm.out_ready = 1'b0;
      bm.bus_valid = 1'b1;
      bm.bus_in = {1'b0, 32'h55};
      cyc();
      bm.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bm.bus_in = {i[0], 32'(i)};
         cyc();
         n_tests++;
         if (bm.bus_ready !== 1'b1 || bm.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_%0d: got rdy %b vld %b, want 1 1", i, bm.bus_ready, bm.out_valid);
         end
      end
      bm.bus_valid = 1'b0;
      cyc();
      cyc();
      n_tests++;
      if (bm.out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got vld %b pending %0d, want 0 0", bm.out_valid, sb.size());
      end
   endtask

   task automatic test_toggle();
      do_reset();
      dbi_en = 1'b1;
      bm.out_ready = 1'b1;
      bm.bus_valid = 1'b1;
      bm.bus_in = {1'b0, 32'h0000_000F};
      cyc();
      n_tests++;
      if (toggle_cnt !== 4) begin
         n_fail++; $display("FAIL tog_1: got %0d, want 4", toggle_cnt);
      end
      bm.bus_in = {1'b1, 32'h0000_00F0};
      cyc();
      n_tests++;
      if (toggle_cnt !== 13) begin
         n_fail++; $display("FAIL tog_2: got %0d, want 13", toggle_cnt);
      end
      cyc();
      n_tests++;
      if (toggle_cnt !== 13 || inv_cnt !== 2) begin
         n_fail++; $display("FAIL tog_3: got %0d inv %0d, want 13 2", toggle_cnt, inv_cnt);
      end
      bm.bus_valid = 1'b0;
      bm.bus_in = {1'b1, 32'hFFFF_FFFF};
      cyc();
      n_tests++;
      if (toggle_cnt !== 13 || word_cnt !== 3) begin
         n_fail++; $display("FAIL tog_idle: got %0d words %0d, want 13 3", toggle_cnt, word_cnt);
      end
      // {0,0} against {1,0xF0}: flag plus four data bits
      clear_stats = 1'b1;
      bm.bus_valid = 1'b1;
      bm.bus_in = {1'b0, 32'h0};
      cyc();
      clear_stats = 1'b0;
      bm.bus_valid = 1'b0;
      n_tests++;
      if (toggle_cnt !== 5 || word_cnt !== 1 || inv_cnt !== 0) begin
         n_fail++;
         $display("FAIL clr_acc: got %0d/%0d/%0d, want 1/0/5", word_cnt, inv_cnt, toggle_cnt);
      end
      clear_stats = 1'b1;
      cyc();
      clear_stats = 1'b0;
      n_tests++;
      if ({word_cnt, inv_cnt, toggle_cnt} !== 96'h0) begin
         n_fail++;
         $display("FAIL clr_only: got %0d/%0d/%0d, want 0/0/0", word_cnt, inv_cnt, toggle_cnt);
      end
      bm.bus_valid = 1'b1;
      bm.bus_in = {1'b0, 32'h1};
      cyc();
      bm.bus_valid = 1'b0;
      n_tests++;
      if (toggle_cnt !== 1) begin
         n_fail++; $display("FAIL clr_prev: got %0d, want 1", toggle_cnt);
      end
      cyc();
   endtask

   task automatic test_saturation();
      dbi_en = 1'b1;
      bs.out_ready = 1'b1;
      bs.bus_valid = 1'b1;
      bs.bus_in = {1'b1, 32'hFFFF_FFFF};
      cyc();
      n_tests++;
      if (s_word !== 4'd1 || s_tog !== 4'd15) begin
         n_fail++; $display("FAIL sat_first: got %0d/%0d, want 1/15", s_word, s_tog);
      end
      for (int i = 1; i < 20; i++) begin
         bs.bus_in = {1'b1, (i % 2 == 1) ? 32'h0 : 32'hFFFF_FFFF};
         cyc();
      end
      bs.bus_valid = 1'b0;
      n_tests++;
      if (s_word !== 4'd15 || s_inv !== 4'd15 || s_tog !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_20: got %0d/%0d/%0d, want 15/15/15", s_word, s_inv, s_tog);
      end
      cyc();
   endtask

   task automatic test_reset_flush();
      dbi_en = 1'b0;
      bm.out_ready = 1'b0;
      bm.bus_valid = 1'b1;
      bm.bus_in = {1'b0, 32'h11};
      cyc();
      bm.bus_in = {1'b0, 32'h22};
      cyc();
      bm.bus_valid = 1'b0;
      reset = 1'b1;
      cyc();
      sb.delete();
      n_tests++;
      if (bm.out_valid !== 1'b0 || bm.bus_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_hs: got vld %b rdy %b, want 0 1", bm.out_valid, bm.bus_ready);
      end
      n_tests++;
      if ({word_cnt, inv_cnt, toggle_cnt} !== 96'h0 || s_word !== 4'd0) begin
         n_fail++;
         $display("FAIL flush_cnt: got %0d/%0d/%0d sat %0d, want 0", word_cnt, inv_cnt,
                  toggle_cnt, s_word);
      end
      reset = 1'b0;
      bm.out_ready = 1'b1;
      bm.bus_valid = 1'b1;
      bm.bus_in = {1'b1, 32'h1};
      cyc();
      bm.bus_valid = 1'b0;
      n_tests++;
      if (toggle_cnt !== 2 || inv_cnt !== 0 || bm.data_out !== 32'h1) begin
         n_fail++;
         $display("FAIL flush_prev: got tog %0d inv %0d data %h, want 2 0 1",
                  toggle_cnt, inv_cnt, bm.data_out);
      end
      cyc();
      cyc();
   endtask

   initial begin
      reset = 1'b1;
      dbi_en = 1'b0;
      clear_stats = 1'b0;
      bm.bus_in = '0;
      bm.bus_valid = 1'b0;
      bm.out_ready = 1'b0;
      bs.bus_in = '0;
      bs.bus_valid = 1'b0;
      bs.out_ready = 1'b0;
      test_reset();
      test_decode();
      test_backpressure();
      test_back_to_back();
      test_toggle();
      test_saturation();
      test_reset_flush();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_left: got %0d pending, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
